// File: rtl/brick_update_writer.sv
// Brick-level memory writer: scans a level to count destructible bricks and
// applies collision hits (downgrade brick type, add score, track bricks left).
module brick_update_writer #(
    parameter int X_LIM = 10,
    parameter int Y_LIM = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       level_start,
    input  logic       hit_valid,
    output logic       hit_ready,
    input  logic [3:0] hit_x,
    input  logic [2:0] hit_y,
    output logic [7:0] mem_addr,
    output logic       mem_wren,
    output logic [2:0] mem_wdata,
    input  logic [2:0] mem_rdata,
    output logic [7:0] score,
    output logic [6:0] bricks_left,
    output logic       busy,
    output logic       update_done,
    output logic       level_cleared
);

    localparam int NCELL = X_LIM * Y_LIM;
    localparam int CW    = $clog2(NCELL + 1);

    typedef enum logic [2:0] {IDLE, SCAN, HIT_RD, HIT_CHK, HIT_WR} state_t;

    state_t        state, state_nx;
    logic [7:0]    hit_addr;
    logic          hit_ok;
    logic [2:0]    brick_t;
    logic [CW-1:0] scan_cnt;
    logic          scanned;
    logic [7:0]    addr_calc;
    logic          in_range;
    logic [8:0]    score_sum;

    function automatic logic is_destr(input logic [2:0] t);
        return (t >= 3'd1) && (t <= 3'd4);
    endfunction

    assign addr_calc = 8'(hit_x) + 8'd1 + 8'(32'(hit_y) * X_LIM);
    assign in_range  = (int'(hit_x) < X_LIM) && (int'(hit_y) < Y_LIM);
    assign score_sum = {1'b0, score} + {6'b0, brick_t};

    // state register and datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            hit_addr    <= '0;
            hit_ok      <= 1'b0;
            brick_t     <= '0;
            scan_cnt    <= '0;
            scanned     <= 1'b0;
            score       <= '0;
            bricks_left <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (level_start) begin
                        score       <= '0;
                        bricks_left <= '0;
                        scanned     <= 1'b0;
                        scan_cnt    <= '0;
                    end else if (hit_valid) begin
                        hit_addr <= addr_calc;
                        hit_ok   <= in_range;
                    end
                end
                SCAN: begin
                    scan_cnt <= scan_cnt + 1'b1;
                    // read data lags the address by one cycle
                    if (scan_cnt != '0 && is_destr(mem_rdata))
                        bricks_left <= bricks_left + 7'd1;
                    if (scan_cnt == CW'(NCELL))
                        scanned <= 1'b1;
                end
                HIT_CHK: brick_t <= mem_rdata;
                HIT_WR: begin
                    if (hit_ok && is_destr(brick_t)) begin
                        score <= score_sum[8] ? 8'hFF : score_sum[7:0];
                        if (brick_t == 3'd1 && bricks_left != '0)
                            bricks_left <= bricks_left - 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (level_start)    state_nx = SCAN;
                else if (hit_valid) state_nx = HIT_RD;
            end
            SCAN:    if (scan_cnt == CW'(NCELL)) state_nx = IDLE;
            HIT_RD:  state_nx = HIT_CHK;
            HIT_CHK: state_nx = HIT_WR;
            HIT_WR:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        hit_ready     = (state == IDLE) && !level_start;
        busy          = (state != IDLE);
        update_done   = (state == HIT_WR);
        mem_wren      = (state == HIT_WR) && hit_ok && is_destr(brick_t);
        mem_wdata     = mem_wren ? brick_t - 3'd1 : 3'd0;
        level_cleared = scanned && (bricks_left == '0);
        mem_addr      = 8'd0;
        case (state)
            SCAN:                    mem_addr = (scan_cnt < CW'(NCELL)) ? 8'(scan_cnt) + 8'd1 : 8'd0;
            HIT_RD, HIT_CHK, HIT_WR: mem_addr = hit_addr;
            default:                 mem_addr = 8'd0;
        endcase
    end

endmodule

// File: tb/tb_brick_update_writer.sv
// Directed bench for brick_update_writer with a behavioural level model and
// a synchronous-read level memory.
module tb_brick_update_writer;

    logic       clk = 1'b0;
    logic       reset, level_start, hit_valid;
    logic       hit_ready, mem_wren, busy, update_done, level_cleared;
    logic [3:0] hit_x;
    logic [2:0] hit_y, mem_wdata, mem_rdata;
    logic [7:0] mem_addr, score;
    logic [6:0] bricks_left;

    brick_update_writer dut (
        .clk(clk), .reset(reset), .level_start(level_start),
        .hit_valid(hit_valid), .hit_ready(hit_ready),
        .hit_x(hit_x), .hit_y(hit_y),
        .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .score(score), .bricks_left(bricks_left),
        .busy(busy), .update_done(update_done), .level_cleared(level_cleared)
    );

    always #5 clk = ~clk;

    logic [2:0] mem [0:255];
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_wren) mem[mem_addr] = mem_wdata;
    end

    int n_tests = 0, n_fail = 0;
    int exp_score = 0, exp_bricks = 0;
    bit exp_cleared = 0, scanned_m = 0, run_chk = 0;
    int last_lat, last_wren, last_wdata, last_addr, last_busy;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // every-cycle comparison against the level model
    always @(negedge clk) begin
        if (run_chk && !reset) begin
            chk("hit_ready", hit_ready, int'(!busy && !level_start));
            chk("wren_stray", int'(mem_wren && !update_done), 0);
            if (!busy) begin
                chk("idle_addr", mem_addr, 0);
                chk("score", score, exp_score);
                chk("bricks_left", bricks_left, exp_bricks);
                chk("level_cleared", level_cleared, exp_cleared);
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_score"}, score, 0);
        chk({tag, "_bricks"}, bricks_left, 0);
        chk({tag, "_cleared"}, level_cleared, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_wren"}, mem_wren, 0);
        chk({tag, "_done"}, update_done, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_ready"}, hit_ready, 1);
    endtask

    task automatic clear_mem;
        for (int a = 0; a < 256; a++) mem[a] = 3'd0;
    endtask

    task automatic do_scan(input bit with_hit);
        int n;
        level_start = 1'b1; hit_valid = with_hit; hit_x = 4'd0; hit_y = 3'd0;
        #1;
        if (with_hit) chk("tie_hit_ready", hit_ready, 0);
        tick;
        level_start = 1'b0; hit_valid = 1'b0;
        n = 0;
        for (int a = 1; a <= 80; a++) if (mem[a] >= 1 && mem[a] <= 4) n++;
        exp_bricks = n; exp_score = 0; scanned_m = 1; exp_cleared = (n == 0);
        last_busy = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            last_busy++;
        end
        chk("scan_end", busy, 0);
        tick;
    endtask

    task automatic do_hit(input int x, input int y, input bit ls_mid);
        int a, t;
        bit inr, wr, seen;
        a = (x + 1 + y * 10) & 255;
        inr = (x < 10) && (y < 8);
        t = mem[a];
        wr = inr && t >= 1 && t <= 4;
        hit_x = 4'(x); hit_y = 3'(y); hit_valid = 1'b1;
        #1;
        chk("accept_ready", hit_ready, 1);
        tick;
        hit_valid = 1'b0;
        if (wr) begin
            exp_score = (exp_score + t > 255) ? 255 : exp_score + t;
            if (t == 1 && exp_bricks > 0) exp_bricks--;
        end
        exp_cleared = scanned_m && exp_bricks == 0;
        seen = 0; last_lat = 0;
        for (int i = 1; i <= 6 && !seen; i++) begin
            @(negedge clk);
            if (ls_mid) level_start = (i == 1);
            chk("hit_addr", mem_addr, a);
            if (update_done) begin
                seen = 1; last_lat = i;
                last_wren = mem_wren; last_wdata = mem_wdata; last_addr = mem_addr;
                chk("hit_wren", mem_wren, int'(wr));
                if (wr) chk("hit_wdata", mem_wdata, t - 1);
            end
        end
        chk("hit_seen", seen, 1);
        chk("hit_latency", last_lat, 3);
        level_start = 1'b0;
        tick;
    endtask

    initial begin
        reset = 1'b1; level_start = 1'b0; hit_valid = 1'b0;
        hit_x = 4'd0; hit_y = 3'd0;
        clear_mem;
        repeat (3) tick;
        chk_reset_vals("rst");
        reset = 1'b0;
        run_chk = 1;
        tick;

        // 12 destructible cells including both end addresses
        mem[1] = 3'd1;  mem[5] = 3'd1;  mem[10] = 3'd3; mem[11] = 3'd4;
        mem[24] = 3'd4; mem[33] = 3'd2; mem[40] = 3'd1; mem[50] = 3'd3;
        mem[61] = 3'd2; mem[70] = 3'd4; mem[79] = 3'd1; mem[80] = 3'd2;
        do_scan(0);
        chk("scan_busy_cycles", last_busy, 81);
        chk("scan_bricks_lit", bricks_left, 12);
        chk("scan_cleared_lit", level_cleared, 0);

        do_hit(3, 2, 0);
        chk("h41_addr", last_addr, 24);
        chk("h41_wdata", last_wdata, 3);
        chk("h41_lat", last_lat, 3);
        chk("h41_score", score, 4);
        do_hit(3, 2, 0);
        chk("h41b_wdata", last_wdata, 2);
        chk("h41b_score", score, 7);
        do_hit(4, 0, 1);
        chk("t1_score", score, 8);
        chk("t1_bricks", bricks_left, 11);
        chk("ls_busy_ignored", busy, 0);

        clear_mem;
        mem[80] = 3'd1;
        do_scan(0);
        chk("one_brick", bricks_left, 1);
        do_hit(9, 7, 0);
        chk("h42_wdata", last_wdata, 0);
        chk("h42_score", score, 1);
        chk("h42_bricks", bricks_left, 0);
        chk("h42_cleared", level_cleared, 1);

        do_hit(9, 7, 0);
        chk("h43_t0_wren", last_wren, 0);
        mem[1] = 3'd6;
        do_hit(0, 0, 0);
        chk("h43_t6_wren", last_wren, 0);
        mem[11] = 3'd4;
        do_hit(10, 0, 0);
        chk("h43_oor_wren", last_wren, 0);
        chk("h43_score", score, 1);
        chk("h43_mem11", mem[11], 4);

        do_scan(1);
        chk("tie_bricks", bricks_left, 1);
        chk("tie_score", score, 0);

        for (int k = 0; k < 63; k++) begin
            mem[2] = 3'd4;
            do_hit(1, 0, 0);
        end
        chk("sat_252", score, 252);
        mem[2] = 3'd1;
        do_hit(1, 0, 0);
        chk("sat_253", score, 253);
        mem[2] = 3'd4;
        do_hit(1, 0, 0);
        chk("sat_255", score, 255);
        mem[2] = 3'd3;
        do_hit(1, 0, 0);
        chk("sat_hold", score, 255);

        // reset while in HIT_CHK
        mem[2] = 3'd4;
        hit_x = 4'd1; hit_y = 3'd0; hit_valid = 1'b1;
        tick;
        hit_valid = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        exp_score = 0; exp_bricks = 0; scanned_m = 0; exp_cleared = 0;
        chk_reset_vals("rst_hit");
        repeat (4) begin
            @(negedge clk);
            chk("rst_hit_nodone", update_done, 0);
        end
        chk("rst_hit_mem", mem[2], 4);
        tick;

        // reset at scan address 40
        level_start = 1'b1;
        tick;
        level_start = 1'b0;
        begin
            bit found;
            found = 0;
            for (int i = 0; i < 100 && !found; i++) begin
                @(negedge clk);
                if (mem_addr == 8'd40) found = 1;
            end
            chk("scan40_found", found, 1);
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk_reset_vals("rst_scan");
        tick;
        chk("rst_scan_ready_next", hit_ready, 1);
        chk("rst_scan_busy_next", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/brick_update_writer.md
BRICK_UPDATE_WRITER -- requirements
Module: brick_update_writer

Interface
REQ-001 Parameter X_LIM, default 10, bricks per row.
REQ-002 Parameter Y_LIM, default 8, brick rows.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 level_start  in  1  one-cycle pulse; requests a level scan.
REQ-006 hit_valid  in  1  collision request valid.
REQ-007 hit_ready  out  1  writer can accept a hit.
REQ-008 hit_x  in  4  brick column of hit.
REQ-009 hit_y  in  3  brick row of hit.
REQ-010 mem_addr  out  8  level memory address.
REQ-011 mem_wren  out  1  level memory write enable.
REQ-012 mem_wdata  out  3  level memory write data.
REQ-013 mem_rdata  in  3  level memory read data, valid one cycle after mem_addr is presented.
REQ-014 score  out  8  accumulated score.
REQ-015 bricks_left  out  7  count of destructible bricks remaining.
REQ-016 busy  out  1  high in any non-IDLE state.
REQ-017 update_done  out  1  one-cycle pulse when a hit completes.
REQ-018 level_cleared  out  1  high when a scan has completed and bricks_left = 0.

Function
REQ-019 Brick address: hit_x + 1 + hit_y*X_LIM, computed at 8 bits; valid addresses are 1..X_LIM*Y_LIM (1..80).
REQ-020 Brick types: 0 none, 1 red, 2 brown, 3 strong red, 4 strong brown; types 5-7 are indestructible.
REQ-021 States: IDLE, SCAN, HIT_RD, HIT_CHK, HIT_WR.
REQ-022 hit_ready = 1 only in IDLE; a hit is accepted on a clock edge where hit_valid && hit_ready.
REQ-023 Accepted hit: registers hit_x and hit_y, then IDLE -> HIT_RD -> HIT_CHK -> HIT_WR -> IDLE, one cycle per state.
REQ-024 mem_addr holds the registered brick address from HIT_RD through HIT_WR; mem_rdata is sampled in HIT_CHK.
REQ-025 In HIT_WR, when the sampled type t is in 1..4: mem_wren = 1, mem_wdata = t-1, score += t (saturating at 255).
REQ-026 In HIT_WR, when t = 1: bricks_left decrements, with no decrement below 0.
REQ-027 When t = 0 or t >= 5: mem_wren = 0, and score and bricks_left do not change.
REQ-028 Out-of-range hit (hit_x >= X_LIM or hit_y >= Y_LIM): runs the same state sequence with mem_wren = 0 and no score or count change.
REQ-029 update_done pulses high for exactly the HIT_WR cycle of every accepted hit; the next accept is possible one cycle after HIT_WR.
REQ-030 level_start in IDLE: enter SCAN; bricks_left and score clear to 0; level_cleared drops.
REQ-031 SCAN: mem_addr steps 1..80, one address per cycle; each mem_rdata is counted one cycle later when it is in 1..4.
REQ-032 SCAN lasts 81 cycles, including the final data cycle, then returns to IDLE and sets the internal scanned flag.
REQ-033 level_start while busy: ignored.
REQ-034 level_start and hit_valid together in IDLE: level_start wins, and hit_ready drops for that edge.
REQ-035 mem_wren is never asserted outside HIT_WR.
REQ-036 mem_addr = 0 in IDLE.

Reset
REQ-037 reset has priority over every input, in any state including mid-SCAN and mid-hit.
REQ-038 On reset: state -> IDLE; score = 0, bricks_left = 0, scanned = 0, mem_wren = 0, update_done = 0, mem_addr = 0, level_cleared = 0.
REQ-039 A hit or scan interrupted by reset is abandoned; no write is issued.

Verification
REQ-040 Scan a memory holding 12 nonzero and 68 zero cells -> busy for 81 cycles, bricks_left = 12, level_cleared = 0.
REQ-041 Hit (x=3, y=2) on type 4 -> mem_addr = 24, mem_wren one cycle with mem_wdata = 3, score += 4, update_done 3 cycles after accept.
REQ-042 Hit on type 1 with bricks_left = 1 -> write 0, score += 1, bricks_left = 0, level_cleared = 1.
REQ-043 Hit on type 0, on type 6, and with x = 10 -> no mem_wren, score unchanged, update_done still pulses.
REQ-044 score = 253 then hit on type 4 -> score = 255.
REQ-045 reset asserted in HIT_CHK, and separately at scan address 40 -> no write, all outputs at reset values, hit_ready = 1 next cycle.
